alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Shares one combinational 32-bit ALU between two requesters (port 0, port 1) using valid/ready handshakes and round-robin arbitration.
- Registers the granted operands and control into the ALU input stage, captures result and flags one cycle later, and returns them on a single response channel tagged with the requester ID.
- One operation in flight at a time. Sits between the decode/issue units and the shared ALU instance.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU datapath.
- CNT_W, 16, width of per-port grant counters (optional feature only).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req0_valid / req1_valid  input  1  request valid, per port.
- req0_ready / req1_ready  output  1  request accepted this cycle, per port.
- req0_ctrl / req1_ctrl  input  4  ALU_control code.
- req0_bonus / req1_bonus  input  3  bonus_control code.
- req0_a / req1_a  input  WIDTH  source 1.
- req0_b / req1_b  input  WIDTH  source 2.
- alu_src1, alu_src2  output  WIDTH  registered operands to the ALU.
- alu_ctrl  output  4  registered ALU_control.
- alu_bonus  output  3  registered bonus_control.
- alu_result  input  WIDTH  ALU result, combinational from the alu_* outputs.
- alu_zero, alu_cout, alu_overflow  input  1  ALU flags.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  requester that issued the operation.
- rsp_result  output  WIDTH  captured result.
- rsp_zero, rsp_cout, rsp_overflow  output  1  captured flags.
- rsp_err  output  1  illegal ALU_control code.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; last_grant=1, so port 0 wins the first tie.
  - All alu_* and rsp_* outputs are 0; req*_ready=0.
- FSM states are IDLE, EXEC, RESP.
- IDLE:
  - req*_ready is combinational: asserted only in IDLE, only for the granted port, and only if that port's valid is high. At most one ready is high per cycle.
  - Grant rule: if only one port is valid, grant it. If both are valid, grant the port != last_grant.
  - On handshake, latch id, ctrl, bonus, a and b; update last_grant.
  - Legal ctrl codes: 0000, 0001, 0010, 0110, 0111, 1100, 1101.
  - Legal ctrl: drive alu_* from the latch and go to EXEC.
  - Illegal ctrl: go to RESP with rsp_result=0, all flags 0, rsp_err=1. The ALU input registers are not updated.
- EXEC (exactly 1 cycle):
  - alu_* stay stable.
  - At the cycle end, capture alu_result, alu_zero, alu_cout and alu_overflow into the rsp_* registers; set rsp_err=0; go to RESP.
- RESP:
  - rsp_valid=1. All rsp_* outputs stay stable until rsp_valid && rsp_ready.
  - On that handshake, go to IDLE and clear rsp_valid.
  - No new request is accepted in the same cycle as the response handshake.
- Latency:
  - Legal op: request handshake at cycle t -> rsp_valid first high at t+2.
  - Illegal op: rsp_valid first high at t+1.
- Throughput: at most one op per 3 cycles (legal) with rsp_ready held high.
- alu_* outputs hold their last value between operations; they are not cleared after use.
- Port requests must hold valid and payload stable until ready. The block does not buffer un-granted requests.
- Reset mid-operation: the in-flight op is dropped with no response, and every output returns to its reset value on the next edge.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- When defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (CNT_W each).
  - Each counter increments on its port's request handshake, saturates at all-ones, and resets to 0.
  - Adds output err_cnt (CNT_W), which counts illegal-ctrl grants and also saturates.
- When undefined: these ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- Port 0 only, ctrl=0010, a=0x7FFFFFFF, b=0x00000001, rsp_ready=1 -> rsp_valid 2 cycles after handshake, rsp_id=0, rsp_result=0x80000000, rsp_overflow=1, rsp_cout=0, rsp_zero=0.
- Both ports valid from reset; port0 SUB a=5 b=5, port1 AND a=0xF0F0F0F0 b=0xFF00FF00 -> port0 granted first with rsp_result=0, rsp_zero=1, rsp_cout=1; then port1 with rsp_result=0xF000F000, rsp_id=1.
- Both ports held valid for 4 ops -> grant order 0,1,0,1, and req0_ready and req1_ready never high in the same cycle.
- Port 1 ctrl=1111 -> rsp_valid 1 cycle after handshake, rsp_err=1, rsp_result=0, alu_* unchanged.
- rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, busy=1, both req*_ready=0; rsp_ready=1 -> IDLE next cycle.
- rst_n=0 during EXEC -> next cycle rsp_valid=0, busy=0, alu_*=0; port 0 wins the next tie. With ALU_ARB_STATS_EN defined: 3 port0 grants plus 1 illegal -> grant_cnt0=3, err_cnt=1 (count before the reset).

Source files
------------

// File: rtl/alu_share_arb.sv
// Two-port round-robin front end that shares one combinational ALU through valid/ready handshakes.
// Optional grant/error counters are built only when ALU_ARB_STATS_EN is defined.
module alu_share_arb #(
    parameter int WIDTH = 32
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_ctrl,
    input  logic [2:0]       req0_bonus,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_ctrl,
    input  logic [2:0]       req1_bonus,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    output logic [3:0]       alu_ctrl,
    output logic [2:0]       alu_bonus,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_cout,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_cout,
    output logic             rsp_overflow,
    output logic             rsp_err,
`ifdef ALU_ARB_STATS_EN
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
    output logic [CNT_W-1:0] err_cnt,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_alu_src1;
    logic [WIDTH-1:0] r_alu_src2;
    logic [3:0]       r_alu_ctrl;
    logic [2:0]       r_alu_bonus;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_zero;
    logic             r_rsp_cout;
    logic             r_rsp_overflow;
    logic             r_rsp_err;

    logic             w_pick1;
    logic             w_hs0;
    logic             w_hs1;
    logic             w_hs;
    logic             w_legal;
    logic [3:0]       w_ctrl;
    logic [2:0]       w_bonus;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    function automatic logic is_legal(input logic [3:0] code);
        case (code)
            4'b0000, 4'b0001, 4'b0010, 4'b0110,
            4'b0111, 4'b1100, 4'b1101: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // NOTE: ready is combinational from valid so the grant lands in the same cycle; gating with
    // rst_n keeps both readies low while reset is held.
    assign w_pick1    = req1_valid && (!req0_valid || !r_last_grant);
    assign w_hs0      = rst_n && (r_state == S_IDLE) && req0_valid && !w_pick1;
    assign w_hs1      = rst_n && (r_state == S_IDLE) && w_pick1;
    assign w_hs       = w_hs0 || w_hs1;
    assign req0_ready = w_hs0;
    assign req1_ready = w_hs1;

    assign w_ctrl  = w_pick1 ? req1_ctrl  : req0_ctrl;
    assign w_bonus = w_pick1 ? req1_bonus : req0_bonus;
    assign w_a     = w_pick1 ? req1_a     : req0_a;
    assign w_b     = w_pick1 ? req1_b     : req0_b;
    assign w_legal = is_legal(w_ctrl);

    // NOTE: every state register uses non-blocking assignment; the synchronous reset clears the
    // ALU operand stage too, since those registers are visible outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_last_grant   <= 1'b1;
            r_alu_src1     <= '0;
            r_alu_src2     <= '0;
            r_alu_ctrl     <= '0;
            r_alu_bonus    <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_zero     <= 1'b0;
            r_rsp_cout     <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_last_grant <= w_pick1;
                        r_rsp_id     <= w_pick1;
                        if (w_legal) begin
                            r_alu_src1  <= w_a;
                            r_alu_src2  <= w_b;
                            r_alu_ctrl  <= w_ctrl;
                            r_alu_bonus <= w_bonus;
                            r_state     <= S_EXEC;
                        end else begin
                            // Illegal code bypasses the ALU and answers with an error response.
                            r_rsp_result   <= '0;
                            r_rsp_zero     <= 1'b0;
                            r_rsp_cout     <= 1'b0;
                            r_rsp_overflow <= 1'b0;
                            r_rsp_err      <= 1'b1;
                            r_rsp_valid    <= 1'b1;
                            r_state        <= S_RESP;
                        end
                    end
                end
                S_EXEC: begin
                    r_rsp_result   <= alu_result;
                    r_rsp_zero     <= alu_zero;
                    r_rsp_cout     <= alu_cout;
                    r_rsp_overflow <= alu_overflow;
                    r_rsp_err      <= 1'b0;
                    r_rsp_valid    <= 1'b1;
                    r_state        <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] r_grant_cnt0;
    logic [CNT_W-1:0] r_grant_cnt1;
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
            r_err_cnt    <= '0;
        end else begin
            if (w_hs0 && (r_grant_cnt0 != '1)) r_grant_cnt0 <= r_grant_cnt0 + CNT_W'(1);
            if (w_hs1 && (r_grant_cnt1 != '1)) r_grant_cnt1 <= r_grant_cnt1 + CNT_W'(1);
            if (w_hs && !w_legal && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
    assign err_cnt    = r_err_cnt;
`endif

    assign alu_src1     = r_alu_src1;
    assign alu_src2     = r_alu_src2;
    assign alu_ctrl     = r_alu_ctrl;
    assign alu_bonus    = r_alu_bonus;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_result   = r_rsp_result;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_cout     = r_rsp_cout;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_err      = r_rsp_err;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb with a behavioural ALU wired to the alu_* stage.
// Counter checks are compiled in when ALU_ARB_STATS_EN is defined.
module tb_alu_share_arb;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;
    localparam int TMO   = 20;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic        zero;
        logic        cout;
        logic        ovf;
        logic        err;
    } rsp_t;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        cout;
        logic        ovf;
    } alu_out_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic req0_ready, req1_ready;
    logic [3:0] req0_ctrl = '0, req1_ctrl = '0;
    logic [2:0] req0_bonus = '0, req1_bonus = '0;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [WIDTH-1:0] alu_src1, alu_src2, alu_result;
    logic [3:0] alu_ctrl;
    logic [2:0] alu_bonus;
    logic alu_zero, alu_cout, alu_overflow;
    logic rsp_valid, rsp_id, rsp_zero, rsp_cout, rsp_overflow, rsp_err, busy;
    logic rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_result;
`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1, err_cnt;
    int g_cnt[2];
    int e_cnt;
`endif

    int   n_cmp = 0;
    int   n_fail = 0;
    int   both_cnt = 0;
    rsp_t q[$];
    logic [3:0]  cur_c[2];
    logic [2:0]  cur_bo[2];
    logic [31:0] cur_a[2];
    logic [31:0] cur_b[2];
    logic [70:0] last_alu = '0;
    logic [3:0]  legal_codes[7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101};
    alu_out_t    alu_o;

    always #5 clk = ~clk;

    alu_share_arb #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_bonus(req0_bonus), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_bonus(req1_bonus), .req1_a(req1_a), .req1_b(req1_b),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl), .alu_bonus(alu_bonus),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout),
        .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err),
`ifdef ALU_ARB_STATS_EN
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .err_cnt(err_cnt),
`endif
        .busy(busy)
    );

    function automatic alu_out_t alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        alu_out_t o;
        logic [32:0] s;
        o = '0;
        s = '0;
        case (c)
            4'b0000: o.res = a & b;
            4'b0001: o.res = a | b;
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                o.res = s[31:0]; o.cout = s[32];
                o.ovf = (a[31] == b[31]) && (s[31] != a[31]);
            end
            4'b0110: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                o.res = s[31:0]; o.cout = s[32];
                o.ovf = (a[31] != b[31]) && (s[31] != a[31]);
            end
            4'b0111: o.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: o.res = ~(a | b);
            4'b1101: o.res = a ^ b;
            default: o.res = '0;
        endcase
        o.zero = (o.res == 32'd0);
        return o;
    endfunction

    assign alu_o        = alu_model(alu_ctrl, alu_src1, alu_src2);
    assign alu_result   = alu_o.res;
    assign alu_zero     = alu_o.zero;
    assign alu_cout     = alu_o.cout;
    assign alu_overflow = alu_o.ovf;

    function automatic logic legal(input logic [3:0] c);
        return c inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101};
    endfunction

    function automatic rsp_t expect_of(input logic id, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        alu_out_t o;
        if (!legal(c)) return {id, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        o = alu_model(c, a, b);
        return {id, o.res, o.zero, o.cout, o.ovf, 1'b0};
    endfunction

    function automatic rsp_t cur_rsp();
        return {rsp_id, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err};
    endfunction

    always begin
        @(negedge clk);
        #2;
        if (req0_ready && req1_ready) both_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int p, input logic [3:0] c, input logic [2:0] bo,
                         input logic [31:0] a, input logic [31:0] b);
        cur_c[p] = c; cur_bo[p] = bo; cur_a[p] = a; cur_b[p] = b;
        if (p == 0) begin
            req0_valid = 1'b1; req0_ctrl = c; req0_bonus = bo; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_ctrl = c; req1_bonus = bo; req1_a = a; req1_b = b;
        end
        q.push_back(expect_of(p == 1, c, a, b));
    endtask

    task automatic drive_rand(input int p);
        drive(p, legal_codes[$urandom_range(0, 6)], 3'($urandom), $urandom, $urandom);
    endtask

    task automatic idle_port(input int p);
        if (p == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic note_accept(input int p);
        if (legal(cur_c[p])) last_alu = {cur_a[p], cur_b[p], cur_c[p], cur_bo[p]};
`ifdef ALU_ARB_STATS_EN
        g_cnt[p]++;
        if (!legal(cur_c[p])) e_cnt++;
`endif
    endtask

    // Called right after driving at a negedge; returns at the negedge following the handshake edge.
    task automatic wait_accept(output int port, output int n);
        port = -1;
        n = 0;
        while (port < 0 && n < TMO) begin
            #1;
            if (req0_ready && req1_ready) port = 2;
            else if (req0_ready) port = 0;
            else if (req1_ready) port = 1;
            @(negedge clk);
            if (port < 0) n++;
        end
        if (port == 0 || port == 1) note_accept(port);
    endtask

    // Cycles from the request handshake until rsp_valid is first seen.
    task automatic wait_rsp(output int n);
        n = 1;
        while (!rsp_valid && n < TMO) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`ifdef ALU_ARB_STATS_EN
        g_cnt[0] = 0; g_cnt[1] = 0; e_cnt = 0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({alu_src1, alu_src2, alu_ctrl, alu_bonus} !== '0) begin
            n_fail++; $display("FAIL reset_alu: got %h want 0", {alu_src1, alu_src2, alu_ctrl, alu_bonus});
        end
        n_cmp++;
        if ({cur_rsp(), rsp_valid, busy, req0_ready, req1_ready} !== '0) begin
            n_fail++; $display("FAIL reset_rsp: got %h want 0", {cur_rsp(), rsp_valid, busy, req0_ready, req1_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
`ifdef ALU_ARB_STATS_EN
        g_cnt[0] = 0; g_cnt[1] = 0; e_cnt = 0;
`endif
        @(negedge clk);
    endtask

    task automatic test_add_overflow();
        int p, n;
        rsp_t e;
        drive(0, 4'b0010, 3'b101, 32'h7FFF_FFFF, 32'h0000_0001);
        wait_accept(p, n);
        n_cmp++;
        if (p !== 0) begin n_fail++; $display("FAIL add_grant: got %0d want 0", p); end
        idle_port(0);
        wait_rsp(n);
        n_cmp++;
        if (n !== 2) begin n_fail++; $display("FAIL add_latency: got %0d want 2", n); end
        e = q.pop_front();
        n_cmp++;
        if (cur_rsp() !== e) begin n_fail++; $display("FAIL add_rsp: got %h want %h", cur_rsp(), e); end
        n_cmp++;
        if ({alu_src1, alu_src2, alu_ctrl, alu_bonus} !== {32'h7FFF_FFFF, 32'h1, 4'b0010, 3'b101}) begin
            n_fail++; $display("FAIL add_alu_in: got %h", {alu_src1, alu_src2, alu_ctrl, alu_bonus});
        end
        @(negedge clk);
    endtask

    task automatic test_tie_from_reset();
        int p, n;
        rsp_t e;
        apply_reset();
        drive(0, 4'b0110, 3'b000, 32'd5, 32'd5);
        drive(1, 4'b0000, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        for (int k = 0; k < 2; k++) begin
            wait_accept(p, n);
            n_cmp++;
            if (p !== k) begin n_fail++; $display("FAIL tie_grant%0d: got %0d want %0d", k, p, k); end
            idle_port(k);
            wait_rsp(n);
            n_cmp++;
            if (n !== 2) begin n_fail++; $display("FAIL tie_latency%0d: got %0d want 2", k, n); end
            e = q.pop_front();
            n_cmp++;
            if (cur_rsp() !== e) begin n_fail++; $display("FAIL tie_rsp%0d: got %h want %h", k, cur_rsp(), e); end
        end
    endtask

    task automatic test_round_robin();
        int p, n, pf, issued;
        rsp_t e;
        both_cnt = 0;
        // Port 1 won last, so a sustained tie should alternate 0,1,0,1.
        drive_rand(0);
        drive_rand(1);
        issued = 2;
        for (int k = 0; k < 4; k++) begin
            wait_accept(p, n);
            n_cmp++;
            if (p !== (k % 2)) begin n_fail++; $display("FAIL rr_grant%0d: got %0d want %0d", k, p, k % 2); end
            pf = (p == 0 || p == 1) ? p : k % 2;
            if (issued < 4) begin drive_rand(pf); issued++; end
            else idle_port(pf);
            wait_rsp(n);
            e = q.pop_front();
            n_cmp++;
            if (cur_rsp() !== e) begin n_fail++; $display("FAIL rr_rsp%0d: got %h want %h", k, cur_rsp(), e); end
        end
        n_cmp++;
        if (both_cnt !== 0) begin n_fail++; $display("FAIL rr_both_ready: got %0d cycles want 0", both_cnt); end
    endtask

    task automatic test_illegal();
        int p, n;
        rsp_t e;
        drive(1, 4'b1111, 3'b010, $urandom, $urandom);
        wait_accept(p, n);
        n_cmp++;
        if (p !== 1) begin n_fail++; $display("FAIL ill_grant: got %0d want 1", p); end
        idle_port(1);
        wait_rsp(n);
        n_cmp++;
        if (n !== 1) begin n_fail++; $display("FAIL ill_latency: got %0d want 1", n); end
        e = q.pop_front();
        n_cmp++;
        if (cur_rsp() !== e) begin n_fail++; $display("FAIL ill_rsp: got %h want %h", cur_rsp(), e); end
        n_cmp++;
        if ({alu_src1, alu_src2, alu_ctrl, alu_bonus} !== last_alu) begin
            n_fail++; $display("FAIL ill_alu_hold: got %h want %h", {alu_src1, alu_src2, alu_ctrl, alu_bonus}, last_alu);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int p, n;
        rsp_t e;
        rsp_ready = 1'b0;
        drive_rand(0);
        wait_accept(p, n);
        n_cmp++;
        if (p !== 0) begin n_fail++; $display("FAIL bp_grant: got %0d want 0", p); end
        wait_rsp(n);
        n_cmp++;
        if (n !== 2) begin n_fail++; $display("FAIL bp_latency: got %0d want 2", n); end
        e = q.pop_front();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if ({cur_rsp(), rsp_valid, busy, req0_ready, req1_ready} !== {e, 4'b1100}) begin
                n_fail++; $display("FAIL bp_hold%0d: got %h want %h", i,
                                   {cur_rsp(), rsp_valid, busy, req0_ready, req1_ready}, {e, 4'b1100});
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL bp_release: got %b want 00", {rsp_valid, busy}); end
    endtask

    task automatic test_reset_mid_exec();
        int p, n;
        rsp_t e;
        drive_rand(0);
        wait_accept(p, n);
        n_cmp++;
        if (p !== 0) begin n_fail++; $display("FAIL mid_grant: got %0d want 0", p); end
        idle_port(0);
`ifdef ALU_ARB_STATS_EN
        n_cmp++;
        if ({grant_cnt0, grant_cnt1, err_cnt} !== {CNT_W'(g_cnt[0]), CNT_W'(g_cnt[1]), CNT_W'(e_cnt)}) begin
            n_fail++; $display("FAIL stats_pre: got %0d/%0d/%0d want %0d/%0d/%0d",
                               grant_cnt0, grant_cnt1, err_cnt, g_cnt[0], g_cnt[1], e_cnt);
        end
`endif
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        n_cmp++;
        if ({alu_src1, alu_src2, alu_ctrl, alu_bonus} !== '0) begin
            n_fail++; $display("FAIL mid_alu: got %h want 0", {alu_src1, alu_src2, alu_ctrl, alu_bonus});
        end
        n_cmp++;
        if ({cur_rsp(), rsp_valid, busy} !== '0) begin
            n_fail++; $display("FAIL mid_rsp: got %h want 0", {cur_rsp(), rsp_valid, busy});
        end
`ifdef ALU_ARB_STATS_EN
        n_cmp++;
        if ({grant_cnt0, grant_cnt1, err_cnt} !== '0) begin
            n_fail++; $display("FAIL stats_reset: got %0d/%0d/%0d want 0", grant_cnt0, grant_cnt1, err_cnt);
        end
        g_cnt[0] = 0; g_cnt[1] = 0; e_cnt = 0;
`endif
        drive_rand(0);
        drive_rand(1);
        rst_n = 1'b1;
        wait_accept(p, n);
        n_cmp++;
        if (p !== 0) begin n_fail++; $display("FAIL mid_tie: got %0d want 0", p); end
        idle_port(0);
        idle_port(1);
        void'(q.pop_back());
        wait_rsp(n);
        n_cmp++;
        if (n !== 2) begin n_fail++; $display("FAIL mid_latency: got %0d want 2", n); end
        e = q.pop_front();
        n_cmp++;
        if (cur_rsp() !== e) begin n_fail++; $display("FAIL mid_rsp2: got %h want %h", cur_rsp(), e); end
`ifdef ALU_ARB_STATS_EN
        n_cmp++;
        if ({grant_cnt0, grant_cnt1, err_cnt} !== {CNT_W'(g_cnt[0]), CNT_W'(g_cnt[1]), CNT_W'(e_cnt)}) begin
            n_fail++; $display("FAIL stats_post: got %0d/%0d/%0d want %0d/%0d/%0d",
                               grant_cnt0, grant_cnt1, err_cnt, g_cnt[0], g_cnt[1], e_cnt);
        end
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_tie_from_reset();
        test_round_robin();
        test_illegal();
        test_backpressure();
        test_reset_mid_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
